// File: rtl/hub75_fb_writer.sv
// hub75_fb_writer: raster pixel stream into the HUB75 framebuffer write side.
// Optional HUB75_FBW_SYNC_CHECK_EN: a misplaced in_sof restarts the frame.
module hub75_fb_writer #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int N_CHANS     = 3,
  parameter int N_PLANES    = 8,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CHANS*N_PLANES-1:0]   in_data,
  input  logic                          in_sof,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LOG_N_BANKS-1:0]        fb_wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]         fb_wr_row_addr,
  output logic                          fb_wr_row_store,
  input  logic                          fb_wr_row_rdy,
  output logic                          fb_wr_row_swap,
  output logic [N_CHANS*N_PLANES-1:0]   fb_wr_data,
  output logic [LOG_N_COLS-1:0]         fb_wr_col_addr,
  output logic                          fb_wr_en,
  output logic                          fb_frame_swap,
  output logic                          frame_done,
  output logic                          err_sync
);

  localparam int DW = N_CHANS * N_PLANES;
  localparam int LW = LOG_N_BANKS + LOG_N_ROWS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_WAIT, ST_STORE, ST_FLUSH
  } state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          line_q, line_d;
  logic [LOG_N_COLS-1:0]  col_q, col_d;
  logic                   rdy_q, rdy_d;
  logic                   wr_en_q, wr_en_d;
  logic [DW-1:0]          wr_data_q, wr_data_d;
  logic [LOG_N_COLS-1:0]  wr_col_q, wr_col_d;
  logic [LOG_N_BANKS-1:0] bank_q, bank_d;
  logic [LOG_N_ROWS-1:0]  row_q, row_d;
  logic                   store_q, store_d;
  logic                   fswap_q, fswap_d;
  logic                   err_q, err_d;

  logic acc;
  logic col_last;
  logic line_last;
  logic sync_err;

  assign acc       = in_valid & rdy_q;
  assign col_last  = &col_q;
  assign line_last = &line_q;

`ifdef HUB75_FBW_SYNC_CHECK_EN
  assign sync_err = acc && in_sof && (state_q == ST_FILL)
                    && ((col_q != '0) || (line_q != '0));
`else
  assign sync_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_col_d  = wr_col_q;
    bank_d    = bank_q;
    row_d     = row_q;
    store_d   = 1'b0;
    fswap_d   = 1'b0;
    err_d     = sync_err;
    unique case (state_q)
      ST_IDLE: begin
        if (acc && in_sof) begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          wr_col_d  = '0;
          col_d     = LOG_N_COLS'(1);
          line_d    = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (sync_err) begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          wr_col_d  = '0;
          col_d     = LOG_N_COLS'(1);
          line_d    = '0;
        end else if (acc) begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          wr_col_d  = col_q;
          col_d     = col_q + 1'b1;
          if (col_last) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fb_wr_row_rdy) begin
          store_d = 1'b1;
          bank_d  = line_q[LW-1 -: LOG_N_BANKS];
          row_d   = line_q[LOG_N_ROWS-1:0];
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        if (line_last) begin
          state_d = ST_FLUSH;
        end else begin
          // next line fills while the framebuffer commits this one
          line_d  = line_q + 1'b1;
          col_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        if (fb_wr_row_rdy) begin
          fswap_d = 1'b1;
          line_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      col_q     <= '0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_col_q  <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      store_q   <= 1'b0;
      fswap_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      col_q     <= col_d;
      rdy_q     <= rdy_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_col_q  <= wr_col_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      store_q   <= store_d;
      fswap_q   <= fswap_d;
      err_q     <= err_d;
    end
  end

  assign in_ready        = rdy_q;
  assign fb_wr_en        = wr_en_q;
  assign fb_wr_data      = wr_data_q;
  assign fb_wr_col_addr  = wr_col_q;
  assign fb_wr_bank_addr = bank_q;
  assign fb_wr_row_addr  = row_q;
  assign fb_wr_row_store = store_q;
  assign fb_wr_row_swap  = store_q;
  assign fb_frame_swap   = fswap_q;
  assign frame_done      = fswap_q;
  assign err_sync        = err_q;

endmodule

// File: tb/tb_hub75_fb_writer.sv
// tb_hub75_fb_writer: directed bench for hub75_fb_writer, 64x64 frame.
// Covers HUB75_FBW_SYNC_CHECK_EN both defined and undefined.
module tb_hub75_fb_writer;

  localparam int NB = 2;
  localparam int NR = 32;
  localparam int NC = 64;
  localparam int NL = NB * NR;
  localparam int DW = 24;
`ifdef HUB75_FBW_SYNC_CHECK_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:0]    fb_wr_bank_addr;
  logic [4:0]    fb_wr_row_addr;
  logic          fb_wr_row_store;
  logic          fb_wr_row_rdy = 1'b1;
  logic          fb_wr_row_swap;
  logic [DW-1:0] fb_wr_data;
  logic [5:0]    fb_wr_col_addr;
  logic          fb_wr_en;
  logic          fb_frame_swap;
  logic          frame_done;
  logic          err_sync;

  always #5 clk = ~clk;

  hub75_fb_writer #(
    .N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .N_CHANS(3), .N_PLANES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready),
    .fb_wr_bank_addr(fb_wr_bank_addr), .fb_wr_row_addr(fb_wr_row_addr),
    .fb_wr_row_store(fb_wr_row_store), .fb_wr_row_rdy(fb_wr_row_rdy),
    .fb_wr_row_swap(fb_wr_row_swap), .fb_wr_data(fb_wr_data),
    .fb_wr_col_addr(fb_wr_col_addr), .fb_wr_en(fb_wr_en),
    .fb_frame_swap(fb_frame_swap), .frame_done(frame_done),
    .err_sync(err_sync)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  logic [29:0] wq[$];
  logic [5:0]  sq[$];
  int n_wr, n_st, n_fs, n_fd, n_err, n_bad;
  int unsigned last_st_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: samples just after each active edge, inputs move on negedge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (fb_wr_en) begin
        n_wr++;
        wq.push_back({fb_wr_col_addr, fb_wr_data});
      end
      if (fb_wr_row_store) begin
        n_st++;
        sq.push_back({fb_wr_bank_addr, fb_wr_row_addr});
        last_st_cyc = cyc;
        if (!fb_wr_row_rdy) n_bad++;
      end
      if (fb_wr_row_swap != fb_wr_row_store) n_bad++;
      if (fb_frame_swap) begin
        n_fs++;
        if (!fb_wr_row_rdy || (cyc - last_st_cyc) < 2) n_bad++;
      end
      if (frame_done) n_fd++;
      if (err_sync) n_err++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pix(input int l, input int c);
    return {8'(l), 8'(c), 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wq.delete();
    sq.delete();
    n_wr = 0; n_st = 0; n_fs = 0; n_fd = 0; n_err = 0; n_bad = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 64'(n), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_line(input int l, input int c0, input int c1,
                           input bit gaps);
    for (int c = c0; c < c1; c++) begin
      if (gaps && $urandom_range(1) == 1) @(negedge clk);
      send(pix(l, c), (l == 0 && c == 0));
    end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 40 && n_fs == 0; i++) @(negedge clk);
    if (n_fs == 0) chk("frame_swap_timeout", 64'(n_fs), 64'(1));
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input string p);
    int bad = 0;
    int sbad = 0;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < NC; c++) begin
        int i = l * NC + c;
        if (i >= wq.size() || wq[i] !== {6'(c), pix(l, c)}) bad++;
      end
    for (int i = 0; i < NL; i++)
      if (i >= sq.size() || sq[i] !== {1'(i / NR), 5'(i % NR)}) sbad++;
    chk({p, "_wr_count"}, 64'(n_wr), 64'(NL * NC));
    chk({p, "_pix_bad"}, 64'(bad), 64'(0));
    chk({p, "_store_count"}, 64'(n_st), 64'(NL));
    chk({p, "_store_seq_bad"}, 64'(sbad), 64'(0));
    chk({p, "_frame_swap"}, 64'(n_fs), 64'(1));
    chk({p, "_frame_done"}, 64'(n_fd), 64'(1));
    chk({p, "_protocol_bad"}, 64'(n_bad), 64'(0));
  endtask

  initial begin
    int unsigned t0;
    int bad;
    logic [5:0] c_first;
    clr();
    last_st_cyc = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'(0));
    chk("rst_strobes", 64'({fb_wr_en, fb_wr_row_store, fb_wr_row_swap,
        fb_frame_swap, frame_done, err_sync}), 64'(0));
    chk("rst_wdata", 64'({fb_wr_data, fb_wr_col_addr}), 64'(0));
    chk("rst_addr", 64'({fb_wr_bank_addr, fb_wr_row_addr}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_rise", 64'(in_ready), 64'(1));

    // garbage before sof
    for (int i = 0; i < 10; i++) send(24'hDEAD00 + 24'(i), 1'b0);
    repeat (3) @(negedge clk);
    chk("garbage_no_wr", 64'(n_wr), 64'(0));
    chk("garbage_ready", 64'(in_ready), 64'(1));

    // full frame, continuous valid, rdy=1
    clr();
    t0 = cyc;
    for (int l = 0; l < NL; l++) send_line(l, 0, NC, 1'b0);
    chk("frame_cycles", 64'(cyc - t0), 64'(NL * NC + (NL - 1) * 2));
    wait_fs();
    c_first = (wq.size() > 0) ? wq[0][29:24] : 6'h3F;
    chk("sof_col0", 64'(c_first), 64'(0));
    check_frame("cont");

    // backpressure after line 0
    clr();
    fb_wr_row_rdy = 1'b0;
    send_line(0, 0, NC, 1'b0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    chk("bp_ready_low", 64'(bad), 64'(0));
    chk("bp_no_store", 64'(n_st), 64'(0));
    fb_wr_row_rdy = 1'b1;
    @(negedge clk);
    chk("bp_store_now", 64'(fb_wr_row_store), 64'(1));
    chk("bp_store_count", 64'(n_st), 64'(1));
    chk("bp_store_addr", 64'({fb_wr_bank_addr, fb_wr_row_addr}), 64'(0));

    // reset at line 5, column 40
    for (int l = 1; l < 5; l++) send_line(l, 0, NC, 1'b0);
    send_line(5, 0, 40, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({fb_wr_en, fb_wr_row_store, fb_wr_row_swap,
        fb_frame_swap, frame_done, err_sync, fb_wr_data, fb_wr_col_addr,
        fb_wr_bank_addr, fb_wr_row_addr}), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_stores", 64'(n_st), 64'(5));
    chk("midrst_no_fswap", 64'(n_fs), 64'(0));

    // sof in the middle of line 3
    clr();
    for (int l = 0; l < 3; l++) send_line(l, 0, NC, 1'b0);
    send_line(3, 0, 17, 1'b0);
    send(24'hC0FFEE, 1'b1);
    if (SYNC != 0) send_line(0, 1, NC, 1'b0);
    else send_line(3, 18, NC, 1'b0);
    repeat (10) @(negedge clk);
    c_first = (wq.size() > 209) ? wq[209][29:24] : 6'h3F;
    chk("sync_err_count", 64'(n_err), 64'(SYNC));
    chk("sync_pix_col", 64'(c_first), 64'(SYNC != 0 ? 0 : 17));
    chk("sync_pix_data", 64'((wq.size() > 209) ? wq[209][23:0] : 24'h0),
        64'(24'hC0FFEE));
    chk("sync_store_count", 64'(n_st), 64'(4));
    chk("sync_next_row", 64'((sq.size() > 3) ? sq[3] : 6'h3F),
        64'(SYNC != 0 ? 0 : 3));
    chk("sync_no_fswap", 64'(n_fs), 64'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // full frame with random valid gaps
    clr();
    for (int l = 0; l < NL; l++) send_line(l, 0, NC, 1'b1);
    wait_fs();
    check_frame("gaps");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
